// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO result registers for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per clock; abortable by req.
module mdu_iter #(
  parameter int W         = 32,
  parameter bit EARLY_MUL = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   md_op,
  input  logic [1:0]   hilo_rop,
  input  logic [W-1:0] num1,
  input  logic [W-1:0] num2,
  input  logic         req,
  output logic         busy,
  output logic [W-1:0] hilo_out,
  output logic         div_zero
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic             div_zero_q, div_zero_d;
  // acc: product (mult), {remainder, dividend/quotient} (div), raw num1 (div by zero)
  logic [2*W-1:0]   acc_q, acc_d;
  // opa: shifted multiplicand (mult), divisor in the low half (div)
  logic [2*W-1:0]   opa_q, opa_d;
  logic [W-1:0]     mplr_q, mplr_d;
  logic             is_div_q, is_div_d;
  logic             dz_q, dz_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;

  logic             sgn_op, s1, s2;
  logic [W-1:0]     mag1, mag2;
  logic [W:0]       div_tmp, div_trial;
  logic [W-1:0]     div_rem;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     quot_fix, rem_fix;

  assign sgn_op = (md_op == 3'd1) || (md_op == 3'd3);
  assign s1     = sgn_op & num1[W-1];
  assign s2     = sgn_op & num2[W-1];
  assign mag1   = s1 ? -num1 : num1;
  assign mag2   = s2 ? -num2 : num2;

  // Restoring step: borrow out of the trial subtract means the divisor did not fit
  assign div_tmp   = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_trial = div_tmp - {1'b0, opa_q[W-1:0]};
  assign div_rem   = div_trial[W] ? div_tmp[W-1:0] : div_trial[W-1:0];

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quot_fix = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
      acc_q      <= '0;
      opa_q      <= '0;
      mplr_q     <= '0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
      acc_q      <= acc_d;
      opa_q      <= opa_d;
      mplr_q     <= mplr_d;
      is_div_q   <= is_div_d;
      dz_q       <= dz_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    acc_d      = acc_q;
    opa_d      = opa_q;
    mplr_d     = mplr_q;
    is_div_d   = is_div_q;
    dz_d       = dz_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (!req) begin
          case (md_op)
            3'd1, 3'd2: begin
              acc_d    = '0;
              opa_d    = {{W{1'b0}}, mag1};
              mplr_d   = mag2;
              neg_d    = s1 ^ s2;
              is_div_d = 1'b0;
              dz_d     = 1'b0;
              cnt_d    = CW'(W);
              state_d  = S_MUL;
            end
            3'd3, 3'd4: begin
              is_div_d = 1'b1;
              if (num2 == '0) begin
                dz_d    = 1'b1;
                acc_d   = {{W{1'b0}}, num1};
                state_d = S_FIX;
              end else begin
                dz_d       = 1'b0;
                acc_d      = {{W{1'b0}}, mag1};
                opa_d      = {{W{1'b0}}, mag2};
                neg_d      = s1 ^ s2;
                neg_rem_d  = s1;
                div_zero_d = 1'b0;
                cnt_d      = CW'(W);
                state_d    = S_DIV;
              end
            end
            3'd5:    hi_d = num1;
            3'd6:    lo_d = num1;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d  = mplr_q[0] ? acc_q + opa_q : acc_q;
        opa_d  = opa_q << 1;
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1) || (EARLY_MUL && mplr_q[W-1:1] == '0))
          state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = {div_rem, acc_q[W-2:0], ~div_trial[W]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = S_FIX;
      end
      S_FIX: begin
        if (dz_q) begin
          lo_d       = '1;
          hi_d       = acc_q[W-1:0];
          div_zero_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including the FIX write-back
    if (req && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;
    end
  end

  assign busy     = (state_q != S_IDLE) || (md_op != 3'd0);
  assign div_zero = div_zero_q;

  always_comb begin
    hilo_out = '0;
    if (state_q == S_IDLE) begin
      if (hilo_rop == 2'b01)      hilo_out = hi_q;
      else if (hilo_rop == 2'b10) hilo_out = lo_q;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (W=32): a normal and an early-out instance share stimulus,
// results are checked against a behavioural model through a scoreboard queue.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic [1:0]  hilo_rop;
  logic [31:0] num1, num2;
  logic        req;
  logic        busy, busy_e;
  logic [31:0] hilo_out, hilo_e;
  logic        div_zero, dz_e;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] hi_m = '0, lo_m = '0;
  logic        dz_m = 1'b0;

  mdu_iter #(.W(32), .EARLY_MUL(1'b0)) u_dut (
    .clk(clk), .reset(reset), .md_op(md_op), .hilo_rop(hilo_rop),
    .num1(num1), .num2(num2), .req(req),
    .busy(busy), .hilo_out(hilo_out), .div_zero(div_zero)
  );

  mdu_iter #(.W(32), .EARLY_MUL(1'b1)) u_early (
    .clk(clk), .reset(reset), .md_op(md_op), .hilo_rop(hilo_rop),
    .num1(num1), .num2(num2), .req(req),
    .busy(busy_e), .hilo_out(hilo_e), .div_zero(dz_e)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] rop, output logic [31:0] v, output logic [31:0] ve);
    hilo_rop = rop;
    #1;
    v  = hilo_out;
    ve = hilo_e;
    hilo_rop = 2'b00;
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic dzprev);
    exp_t        e;
    logic [63:0] pp;
    longint      la, lb, q, r;
    logic [63:0] qq, rr;
    e.hi = hi_m; e.lo = lo_m; e.dz = dzprev;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    case (op)
      3'd1: begin pp = 64'(la * lb); e.hi = pp[63:32]; e.lo = pp[31:0]; end
      3'd2: begin pp = {32'b0, a} * {32'b0, b}; e.hi = pp[63:32]; e.lo = pp[31:0]; end
      3'd3, 3'd4: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
        end else if (op == 3'd3) begin
          q = la / lb; r = la % lb;
          qq = 64'(q); rr = 64'(r);
          e.lo = qq[31:0]; e.hi = rr[31:0]; e.dz = 1'b0;
        end else begin
          e.lo = a / b; e.hi = a % b; e.dz = 1'b0;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int edges_m, input int edges_e, input string tag);
    exp_t        e;
    logic [31:0] v, ve;
    int          n, nm, ne;
    e = model(op, a, b, dz_m);
    sb.push_back(e);
    hi_m = e.hi; lo_m = e.lo; dz_m = e.dz;
    md_op = op; num1 = a; num2 = b;
    @(posedge clk); #1;
    md_op = 3'd0;
    n = 0; nm = busy ? -1 : 0; ne = busy_e ? -1 : 0;
    while ((busy || busy_e) && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (!busy && nm < 0)   nm = n;
      if (!busy_e && ne < 0) ne = n;
    end
    if (n >= 100) check({tag, ".timeout"}, 64'(busy | busy_e), 64'd0);
    e = sb.pop_front();
    if (edges_m >= 0) check({tag, ".lat"}, 64'(nm), 64'(edges_m));
    if (edges_e >= 0) check({tag, ".lat_early"}, 64'(ne), 64'(edges_e));
    rd(2'b01, v, ve);
    check({tag, ".hi"}, 64'(v), 64'(e.hi));
    check({tag, ".hi_early"}, 64'(ve), 64'(e.hi));
    rd(2'b10, v, ve);
    check({tag, ".lo"}, 64'(v), 64'(e.lo));
    check({tag, ".lo_early"}, 64'(ve), 64'(e.lo));
    check({tag, ".dz"}, 64'(div_zero), 64'(e.dz));
  endtask

  task automatic check_hilo(input string tag);
    logic [31:0] v, ve;
    rd(2'b01, v, ve);
    check({tag, ".hi"}, 64'(v), 64'(hi_m));
    rd(2'b10, v, ve);
    check({tag, ".lo"}, 64'(v), 64'(lo_m));
    check({tag, ".dz"}, 64'(div_zero), 64'(dz_m));
  endtask

  initial begin
    logic [31:0] v, ve;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; md_op = 3'd0; hilo_rop = 2'b00; num1 = '0; num2 = '0; req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset.busy", 64'(busy), 64'd0);
    check_hilo("reset");
    rd(2'b11, v, ve);
    check("rop11.zero", 64'(v), 64'd0);

    run_op(3'd1, 32'd7, 32'hFFFF_FFFD, 33, -1, "mult_7_m3");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, -1, "multu_max");
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 33, 33, "div_m7_2");
    run_op(3'd4, 32'd100, 32'd0, 1, 1, "divu_by0");
    run_op(3'd4, 32'd9, 32'd3, 33, 33, "divu_9_3");
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 33, 33, "div_min_m1");
    run_op(3'd1, 32'd5, 32'd1, 33, 2, "mult_early");

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : $urandom;
      run_op(rop, ra, rb, (rop >= 3'd3 && rb == 32'd0) ? 1 : 33, -1, "random");
    end

    // mthi / mtlo: busy only during the issuing cycle
    md_op = 3'd5; num1 = 32'h1234; #1;
    check("mthi.busy_issue", 64'(busy), 64'd1);
    @(posedge clk); #1;
    md_op = 3'd6; num1 = 32'h5678; #1;
    check("mtlo.busy_issue", 64'(busy), 64'd1);
    @(posedge clk); #1;
    md_op = 3'd0; #1;
    check("mtlo.busy_after", 64'(busy), 64'd0);
    hi_m = 32'h1234; lo_m = 32'h5678;
    check_hilo("mthi_mtlo");

    // div aborted ten edges after issue
    md_op = 3'd3; num1 = 32'd100; num2 = 32'd7;
    @(posedge clk); #1;
    md_op = 3'd0; dz_m = 1'b0;
    repeat (9) @(posedge clk);
    #1 req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    check("abort.busy", 64'(busy), 64'd0);
    check_hilo("abort");

    // req at issue blocks the op
    req = 1'b1; md_op = 3'd4; num1 = 32'd50; num2 = 32'd5; #1;
    check("req_issue.busy_comb", 64'(busy), 64'd1);
    @(posedge clk); #1;
    md_op = 3'd0; req = 1'b0; #1;
    check("req_issue.busy", 64'(busy), 64'd0);
    check_hilo("req_issue");

    // reset in the middle of a multiply
    md_op = 3'd1; num1 = 32'd3; num2 = 32'd4;
    @(posedge clk); #1;
    md_op = 3'd0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    hi_m = '0; lo_m = '0; dz_m = 1'b0;
    check("rst_mid.busy", 64'(busy), 64'd0);
    check_hilo("rst_mid");
    md_op = 3'd2; #1;
    check("rst_mid.busy_op", 64'(busy), 64'd1);
    md_op = 3'd0; #1;

    run_op(3'd1, 32'hFFFF_FFF0, 32'd16, 33, -1, "mult_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
